// File: rtl/ce_pkg.sv
// Shared types and constants for the fractional clock-enable bank.
package ce_pkg;

  localparam int unsigned CE_ACC_W = 16;

  typedef struct packed {
    logic [CE_ACC_W-1:0] num;
    logic [CE_ACC_W-1:0] den;
  } ce_ratio_t;

  // A disabled channel: never fires, and den stays nonzero so acc < den holds.
  localparam ce_ratio_t CE_RATIO_OFF = '{num: '0, den: CE_ACC_W'(1)};

  function automatic int unsigned ce_ch_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ce_frac_channel.sv
// One fractional enable channel: a phase accumulator that fires whenever it wraps past den.
module ce_frac_channel
  import ce_pkg::*;
#(
  parameter int unsigned ACC_W = CE_ACC_W
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             load,
  input  logic [ACC_W-1:0] num,
  input  logic [ACC_W-1:0] den,
  input  logic             pause,
  input  logic             clear,
  output logic             ce
);

  logic [ACC_W-1:0] num_q, den_q, acc_q, acc_d;
  logic             ce_q, ce_d;
  logic [ACC_W:0]   sum;
  logic [ACC_W:0]   den_ext;

  assign den_ext = {1'b0, den_q};

  // num <= den and acc < den keep sum below 2*den, so one subtraction suffices.
  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, num_q};
    acc_d = acc_q;
    ce_d  = 1'b0;
    if (load || clear) begin
      acc_d = '0;
    end else if (!pause) begin
      if (sum >= den_ext) begin
        acc_d = ACC_W'(sum - den_ext);
        ce_d  = 1'b1;
      end else begin
        acc_d = sum[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      num_q <= ACC_W'(CE_RATIO_OFF.num);
      den_q <= ACC_W'(CE_RATIO_OFF.den);
      acc_q <= '0;
      ce_q  <= 1'b0;
    end else begin
      if (load) begin
        num_q <= num;
        den_q <= den;
      end
      acc_q <= acc_d;
      ce_q  <= ce_d;
    end
  end

  assign ce = ce_q;

endmodule

// File: rtl/ce_frac_bank.sv
// Bank of fractional clock-enable channels with validated run-time ratio writes,
// per-channel pause and a group phase resync.
module ce_frac_bank
  import ce_pkg::*;
#(
  parameter  int unsigned NUM_CH = 4,
  parameter  int unsigned ACC_W  = CE_ACC_W,
  localparam int unsigned CH_W   = ce_ch_w(NUM_CH)
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_num,
  input  logic [ACC_W-1:0]  cfg_den,
  input  logic [NUM_CH-1:0] pause,
  input  logic              resync,
  output logic [NUM_CH-1:0] ce,
  output logic              cfg_err
);

  logic              cfg_ok;
  logic [NUM_CH-1:0] load;
  logic              cfg_err_q, cfg_err_d;

  // Reject writes that would break acc < den or address a missing channel.
  always_comb begin
    cfg_ok = cfg_wr && (cfg_den != '0) && (cfg_num <= cfg_den) && (32'(cfg_ch) < NUM_CH);
    cfg_err_d = cfg_wr && !cfg_ok;
    load = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      load[i] = cfg_ok && (32'(cfg_ch) == i);
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfg_err = cfg_err_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ce_frac_channel #(
      .ACC_W(ACC_W)
    ) u_ch (
      .clk_sys(clk_sys),
      .reset_n(reset_n),
      .load   (load[g]),
      .num    (cfg_num),
      .den    (cfg_den),
      .pause  (pause[g]),
      .clear  (resync),
      .ce     (ce[g])
    );
  end

endmodule

// File: tb/tb_ce_frac_bank.sv
// Directed bench for ce_frac_bank: ratios, rejects, resync, pause and async reset.
module tb_ce_frac_bank;

  localparam int unsigned NumCh = 3;
  localparam int unsigned AccW  = 16;
  localparam int unsigned ChW   = 2;

  logic             clk_sys = 1'b0;
  logic             reset_n = 1'b0;
  logic             cfg_wr  = 1'b0;
  logic [ChW-1:0]   cfg_ch  = '0;
  logic [AccW-1:0]  cfg_num = '0;
  logic [AccW-1:0]  cfg_den = '0;
  logic [NumCh-1:0] pause   = '0;
  logic             resync  = 1'b0;
  logic [NumCh-1:0] ce;
  logic             cfg_err;

  int checks = 0;
  int errors = 0;

  always #5 clk_sys = ~clk_sys;

  ce_frac_bank #(
    .NUM_CH(NumCh),
    .ACC_W (AccW)
  ) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .cfg_wr (cfg_wr),
    .cfg_ch (cfg_ch),
    .cfg_num(cfg_num),
    .cfg_den(cfg_den),
    .pause  (pause),
    .resync (resync),
    .ce     (ce),
    .cfg_err(cfg_err)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic set_cfg(input int ch, input int num, input int den);
    cfg_ch  = ch[ChW-1:0];
    cfg_num = num[AccW-1:0];
    cfg_den = den[AccW-1:0];
  endtask

  task automatic write_cfg(input int ch, input int num, input int den);
    set_cfg(ch, num, den);
    cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic reject(input string tag, input int ch, input int num, input int den);
    set_cfg(ch, num, den);
    cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
    check_eq({tag, "_err_hi"}, int'(cfg_err), 1);
    tick();
    check_eq({tag, "_err_lo"}, int'(cfg_err), 0);
  endtask

  task automatic wait_pulse(input int idx, input int limit, output int n);
    n = -1;
    for (int k = 1; k <= limit; k++) begin
      tick();
      if (ce[idx]) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first, cnt, bad, last, others, n, n0, n1, early;

    // Reset state
    #12;
    @(negedge clk_sys);
    reset_n = 1'b1;
    tick();
    check_eq("rst_ce", int'(ce), 0);
    check_eq("rst_err", int'(cfg_err), 0);

    // ch0 at 1/10
    write_cfg(0, 1, 10);
    first = -1; cnt = 0; bad = 0; last = 0; others = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (ce[0]) begin
        cnt++;
        if (first < 0) first = k;
        else if (k - last != 10) bad++;
        last = k;
      end
      if (ce[2:1] != '0) others++;
    end
    check_eq("ch0_first", first, 10);
    check_eq("ch0_count", cnt, 3);
    check_eq("ch0_badgap", bad, 0);
    check_eq("ch12_quiet", others, 0);

    // ch1 at 3/34: 30 pulses in 340 cycles, gaps 11 or 12
    write_cfg(1, 3, 34);
    cnt = 0; bad = 0; last = -1;
    for (int k = 1; k <= 340; k++) begin
      tick();
      if (ce[1]) begin
        cnt++;
        if (last >= 0 && (k - last) != 11 && (k - last) != 12) bad++;
        last = k;
      end
    end
    check_eq("ch1_count", cnt, 30);
    check_eq("ch1_badgap", bad, 0);

    // ch2 full rate, then disabled
    write_cfg(2, 7, 7);
    cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (ce[2]) cnt++;
    end
    check_eq("ch2_full", cnt, 20);
    write_cfg(2, 0, 5);
    check_eq("ch2_off_now", int'(ce[2]), 0);
    cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (ce[2]) cnt++;
    end
    check_eq("ch2_off", cnt, 0);

    // Rejected writes leave ch0 at period 10
    reject("den0", 0, 1, 0);
    reject("num_gt_den", 0, 5, 4);
    reject("bad_ch", 3, 1, 2);
    wait_pulse(0, 20, n);
    check_eq("ch0_found", int'(n > 0), 1);
    wait_pulse(0, 20, n);
    check_eq("ch0_period", n, 10);

    // ch0/ch1 at 1/4 out of phase, then resync aligns them
    write_cfg(0, 1, 4);
    tick();
    tick();
    write_cfg(1, 1, 4);
    tick();
    resync = 1'b1;
    tick();
    resync = 1'b0;
    check_eq("resync_ce_low", int'(ce), 0);
    early = 0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (ce[1:0] != '0) early++;
    end
    check_eq("resync_early", early, 0);
    tick();
    check_eq("resync_both", int'(ce[1:0]), 3);

    // Pause ch0 with acc=1 for 13 edges; ch1 keeps running
    tick();
    pause[0] = 1'b1;
    n0 = 0; n1 = 0;
    for (int k = 1; k <= 13; k++) begin
      tick();
      if (ce[0]) n0++;
      if (ce[1]) n1++;
    end
    check_eq("pause_ch0", n0, 0);
    check_eq("pause_ch1", n1, 3);
    pause[0] = 1'b0;
    n0 = -1; n1 = -1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (ce[0] && n0 < 0) n0 = k;
      if (ce[1] && n1 < 0) n1 = k;
    end
    check_eq("resume_ch0", n0, 3);
    check_eq("resume_ch1", n1, 2);

    // Async reset clears ce and a pending cfg_err without a clock edge
    write_cfg(2, 7, 7);
    tick();
    tick();
    set_cfg(0, 1, 0);
    cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
    check_eq("pre_rst_err", int'(cfg_err), 1);
    check_eq("pre_rst_ce2", int'(ce[2]), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("async_ce", int'(ce), 0);
    check_eq("async_err", int'(cfg_err), 0);
    @(negedge clk_sys);
    reset_n = 1'b1;
    cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (ce != '0) cnt++;
    end
    check_eq("post_rst_quiet", cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
